// File: rtl/axi_lite_scmi_mailbox_mc.sv
// Multi-channel SCMI mailbox: NUM_CHANNELS register windows behind one AXI4-Lite slave port.
// Define SCMI_MBOX_LEVEL_IRQ_EN for level interrupts; by default irqs are one-cycle pulses.
module axi_lite_scmi_mailbox_mc #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned NUM_CHANNELS   = 4,
   parameter int unsigned SHMEM_WORDS    = 28,
   parameter type axi_lite_req_t = struct packed {
      logic [AXI_ADDR_WIDTH-1:0] aw_addr;
      logic [2:0]                aw_prot;
      logic                      aw_valid;
      logic [31:0]               w_data;
      logic [3:0]                w_strb;
      logic                      w_valid;
      logic                      b_ready;
      logic [AXI_ADDR_WIDTH-1:0] ar_addr;
      logic [2:0]                ar_prot;
      logic                      ar_valid;
      logic                      r_ready;
   },
   parameter type axi_lite_resp_t = struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   }
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  axi_lite_req_t           axi_lite_mbox_req,
   output axi_lite_resp_t          axi_lite_mbox_rsp,
   output logic [NUM_CHANNELS-1:0] doorbell_irq_o,
   output logic [NUM_CHANNELS-1:0] completion_irq_o
);

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic {WrIdle, WrBresp} wr_state_e;
   typedef enum logic {RdIdle, RdResp} rd_state_e;

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic aw_hs, b_valid, ar_hs, ar_rdy, r_valid;
   logic wr_hit, rd_hit, wr_ctrl_we;
   logic [5:0] wr_ch, wr_word, rd_ch, rd_word;
   logic [31:0] wdata, rd_data, rdata_q;
   logic [3:0] wstrb;
   logic [1:0] bresp_q, rresp_q;

   logic [NUM_CHANNELS-1:0] free_q, err_q, en_q, db_q, cmp_q, db_qual_q, cmp_qual_q;
   logic [31:0] payload_q [NUM_CHANNELS][SHMEM_WORDS];

   logic unused_addr;
   assign unused_addr = ^{axi_lite_mbox_req.aw_addr[AXI_ADDR_WIDTH-1:14],
                          axi_lite_mbox_req.aw_addr[1:0], axi_lite_mbox_req.aw_prot,
                          axi_lite_mbox_req.ar_addr[AXI_ADDR_WIDTH-1:14],
                          axi_lite_mbox_req.ar_addr[1:0], axi_lite_mbox_req.ar_prot};

   assign wr_ch   = axi_lite_mbox_req.aw_addr[13:8];
   assign wr_word = axi_lite_mbox_req.aw_addr[7:2];
   assign rd_ch   = axi_lite_mbox_req.ar_addr[13:8];
   assign rd_word = axi_lite_mbox_req.ar_addr[7:2];
   assign wdata   = axi_lite_mbox_req.w_data;
   assign wstrb   = axi_lite_mbox_req.w_strb;

   assign wr_hit = (32'(wr_ch) < NUM_CHANNELS) && (32'(wr_word) < SHMEM_WORDS + 32'd4);
   assign rd_hit = (32'(rd_ch) < NUM_CHANNELS) && (32'(rd_word) < SHMEM_WORDS + 32'd4);
   // Control registers live in words 0..3 and only take byte lane 0.
   assign wr_ctrl_we = (wr_word[5:2] == 4'd0) && wstrb[0];

   // Write engine
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wr_state_q <= WrIdle;
      else         wr_state_q <= wr_state_d;
   end

   always_comb begin
      wr_state_d = wr_state_q;
      unique case (wr_state_q)
         WrIdle:  if (aw_hs) wr_state_d = WrBresp;
         WrBresp: if (axi_lite_mbox_req.b_ready) wr_state_d = WrIdle;
         default: wr_state_d = WrIdle;
      endcase
   end

   always_comb begin
      aw_hs   = 1'b0;
      b_valid = 1'b0;
      unique case (wr_state_q)
         WrIdle:  aw_hs = axi_lite_mbox_req.aw_valid & axi_lite_mbox_req.w_valid;
         WrBresp: b_valid = 1'b1;
         default: ;
      endcase
   end

   // Read engine
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_state_q <= RdIdle;
      else         rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RdIdle:  if (ar_hs) rd_state_d = RdResp;
         RdResp:  if (axi_lite_mbox_req.r_ready) rd_state_d = RdIdle;
         default: rd_state_d = RdIdle;
      endcase
   end

   always_comb begin
      ar_rdy  = 1'b0;
      r_valid = 1'b0;
      unique case (rd_state_q)
         RdIdle:  ar_rdy = 1'b1;
         RdResp:  r_valid = 1'b1;
         default: ;
      endcase
   end

   assign ar_hs = ar_rdy & axi_lite_mbox_req.ar_valid;

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (rd_ch == 6'(c)) begin
            case (rd_word)
               6'd0: rd_data = {30'd0, err_q[c], free_q[c]};
               6'd1: rd_data = {31'd0, en_q[c]};
               6'd2: rd_data = {31'd0, db_q[c]};
               6'd3: rd_data = {31'd0, cmp_q[c]};
               default: begin
                  for (int w = 0; w < SHMEM_WORDS; w++) begin
                     if (rd_word == 6'(w + 4)) rd_data = payload_q[c][w];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         rresp_q <= RespOkay;
         bresp_q <= RespOkay;
      end else begin
         if (ar_hs) begin
            rdata_q <= rd_hit ? rd_data : '0;
            rresp_q <= rd_hit ? RespOkay : RespSlverr;
         end
         if (aw_hs) bresp_q <= wr_hit ? RespOkay : RespSlverr;
      end
   end

   // Register file; the read path above sees pre-write values in a same-cycle collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         free_q     <= '1;
         err_q      <= '0;
         en_q       <= '0;
         db_q       <= '0;
         cmp_q      <= '0;
         db_qual_q  <= '0;
         cmp_qual_q <= '0;
         payload_q  <= '{default: '0};
      end else begin
         db_qual_q  <= db_q & en_q;
         cmp_qual_q <= cmp_q & en_q;
         if (aw_hs && wr_hit) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
               if (wr_ch == 6'(c)) begin
                  if (wr_ctrl_we) begin
                     unique case (wr_word[1:0])
                        2'd0: begin
                           free_q[c] <= wdata[0];
                           err_q[c]  <= wdata[1];
                        end
                        2'd1: en_q[c]  <= wdata[0];
                        2'd2: db_q[c]  <= wdata[0];
                        2'd3: cmp_q[c] <= wdata[0];
                     endcase
                  end
                  for (int w = 0; w < SHMEM_WORDS; w++) begin
                     if (wr_word == 6'(w + 4)) begin
                        for (int b = 0; b < 4; b++) begin
                           if (wstrb[b]) payload_q[c][w][8*b +: 8] <= wdata[8*b +: 8];
                        end
                     end
                  end
               end
            end
         end
      end
   end

`ifdef SCMI_MBOX_LEVEL_IRQ_EN
   assign doorbell_irq_o   = db_q & en_q;
   assign completion_irq_o = cmp_q & en_q;
`else
   assign doorbell_irq_o   = db_q & en_q & ~db_qual_q;
   assign completion_irq_o = cmp_q & en_q & ~cmp_qual_q;
`endif

   always_comb begin
      axi_lite_mbox_rsp          = '0;
      axi_lite_mbox_rsp.aw_ready = aw_hs;
      axi_lite_mbox_rsp.w_ready  = aw_hs;
      axi_lite_mbox_rsp.b_valid  = b_valid;
      axi_lite_mbox_rsp.b_resp   = bresp_q;
      axi_lite_mbox_rsp.ar_ready = ar_rdy;
      axi_lite_mbox_rsp.r_valid  = r_valid;
      axi_lite_mbox_rsp.r_data   = rdata_q;
      axi_lite_mbox_rsp.r_resp   = rresp_q;
   end

endmodule

// File: tb/tb_axi_lite_scmi_mailbox_mc.sv
// Self-checking bench for axi_lite_scmi_mailbox_mc: vector table, corner sequences, random ops
// checked against a register-map model.
`timescale 1ns/1ps
module tb_axi_lite_scmi_mailbox_mc;

   localparam int unsigned AW  = 64;
   localparam int unsigned NCH = 4;
   localparam int unsigned NW  = 28;

   typedef struct packed {
      logic [AW-1:0] aw_addr;
      logic [2:0]    aw_prot;
      logic          aw_valid;
      logic [31:0]   w_data;
      logic [3:0]    w_strb;
      logic          w_valid;
      logic          b_ready;
      logic [AW-1:0] ar_addr;
      logic [2:0]    ar_prot;
      logic          ar_valid;
      logic          r_ready;
   } req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   } resp_t;

   typedef struct {
      bit          wr;
      logic [63:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   req_t req;
   resp_t rsp;
   logic [NCH-1:0] db_irq, cmp_irq;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   axi_lite_scmi_mailbox_mc #(
      .AXI_ADDR_WIDTH (AW),
      .NUM_CHANNELS   (NCH),
      .SHMEM_WORDS    (NW),
      .axi_lite_req_t (req_t),
      .axi_lite_resp_t(resp_t)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .axi_lite_mbox_req(req),
      .axi_lite_mbox_rsp(rsp),
      .doorbell_irq_o   (db_irq),
      .completion_irq_o (cmp_irq)
   );

   // Register-map model
   bit          m_free [NCH];
   bit          m_err  [NCH];
   bit          m_en   [NCH];
   bit          m_db   [NCH];
   bit          m_cmp  [NCH];
   logic [31:0] m_pay  [NCH][NW];

   function automatic void m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_free[c] = 1; m_err[c] = 0; m_en[c] = 0; m_db[c] = 0; m_cmp[c] = 0;
         for (int w = 0; w < NW; w++) m_pay[c][w] = 32'h0;
      end
   endfunction

   function automatic bit m_decode(input logic [63:0] a, output int ch, output int wd);
      ch = int'((a / 256) % 64);
      wd = int'((a % 256) / 4);
      return (ch < NCH) && (wd < NW + 4);
   endfunction

   function automatic logic [NCH-1:0] m_qual(input bit cmp);
      logic [NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (cmp ? m_cmp[c] : m_db[c]) & m_en[c];
      return r;
   endfunction

   function automatic void m_write(input logic [63:0] a, input logic [31:0] d,
                                   input logic [3:0] s, output logic [1:0] resp);
      int ch, wd;
      if (!m_decode(a, ch, wd)) begin
         resp = 2'b10;
         return;
      end
      resp = 2'b00;
      if (wd < 4) begin
         if (s[0]) begin
            if (wd == 0) begin m_free[ch] = d[0]; m_err[ch] = d[1]; end
            if (wd == 1) m_en[ch] = d[0];
            if (wd == 2) m_db[ch] = d[0];
            if (wd == 3) m_cmp[ch] = d[0];
         end
      end else begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_pay[ch][wd-4][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic void m_read(input logic [63:0] a, output logic [31:0] d,
                                  output logic [1:0] resp);
      int ch, wd;
      d = 32'h0;
      if (!m_decode(a, ch, wd)) begin
         resp = 2'b10;
         return;
      end
      resp = 2'b00;
      if (wd == 0)      d = {30'd0, m_err[ch], m_free[ch]};
      else if (wd == 1) d = {31'd0, m_en[ch]};
      else if (wd == 2) d = {31'd0, m_db[ch]};
      else if (wd == 3) d = {31'd0, m_cmp[ch]};
      else              d = m_pay[ch][wd-4];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got no handshake expected handshake within 20 cycles", name);
   endtask

   task automatic idle_req();
      req = '0;
      req.b_ready = 1'b1;
      req.r_ready = 1'b1;
   endtask

   // Called and returns at a negedge.
   task automatic axi_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      logic [NCH-1:0] qd0, qc0, qd1, qc1, e1d, e1c, e2d, e2c;
      logic [1:0] mresp;
      qd0 = m_qual(0); qc0 = m_qual(1);
      m_write(a, d, s, mresp);
      qd1 = m_qual(0); qc1 = m_qual(1);
`ifdef SCMI_MBOX_LEVEL_IRQ_EN
      e1d = qd1; e1c = qc1; e2d = qd1; e2c = qc1;
`else
      e1d = qd1 & ~qd0; e1c = qc1 & ~qc0; e2d = '0; e2c = '0;
`endif
      req.aw_addr = a; req.w_data = d; req.w_strb = s;
      req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
      #1;
      n = 0;
      while (!(rsp.aw_ready && rsp.w_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n == 20) begin
         timeout("write handshake");
         req.aw_valid = 1'b0; req.w_valid = 1'b0;
         resp = 2'bxx;
         @(negedge clk);
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
      check("bvalid N+1", rsp.b_valid, 1);
      check("bresp vs model", rsp.b_resp, mresp);
      check("doorbell_irq N+1", db_irq, e1d);
      check("completion_irq N+1", cmp_irq, e1c);
      resp = rsp.b_resp;
      @(negedge clk);
      check("bvalid after bready", rsp.b_valid, 0);
      check("doorbell_irq N+2", db_irq, e2d);
      check("completion_irq N+2", cmp_irq, e2c);
   endtask

   task automatic axi_read(input logic [63:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      logic [31:0] md;
      logic [1:0] mr;
      m_read(a, md, mr);
      req.ar_addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b1;
      #1;
      n = 0;
      while (!rsp.ar_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n == 20) begin
         timeout("read handshake");
         req.ar_valid = 1'b0;
         d = 'x; resp = 'x;
         @(negedge clk);
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req.ar_valid = 1'b0;
      check("rvalid N+1", rsp.r_valid, 1);
      d = rsp.r_data;
      resp = rsp.r_resp;
      check("rdata vs model", d, md);
      check("rresp vs model", resp, mr);
      @(negedge clk);
      check("rvalid after rready", rsp.r_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish within 2 ms");
      $fatal(1);
   end

   initial begin
      vec_t tbl [20];
      logic [1:0] r;
      logic [31:0] d;
      logic [63:0] a;
      int ch, wd;

      tbl[0]  = '{0, 64'h000, 32'h0, 4'h0, 32'h1, 2'b00};
      tbl[1]  = '{0, 64'h004, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[2]  = '{0, 64'h108, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[3]  = '{1, 64'h114, 32'hDEADBEEF, 4'b0101, 32'h0, 2'b00};
      tbl[4]  = '{0, 64'h114, 32'h0, 4'h0, 32'h00AD00EF, 2'b00};
      tbl[5]  = '{0, 64'hFFFF_0000_0000_0117, 32'h0, 4'h0, 32'h00AD00EF, 2'b00};
      tbl[6]  = '{1, 64'h400, 32'h1, 4'hF, 32'h0, 2'b10};
      tbl[7]  = '{1, 64'h080, 32'h1, 4'hF, 32'h0, 2'b10};
      tbl[8]  = '{0, 64'h400, 32'h0, 4'h0, 32'h0, 2'b10};
      tbl[9]  = '{0, 64'h0FC, 32'h0, 4'h0, 32'h0, 2'b10};
      tbl[10] = '{1, 64'h204, 32'h1, 4'hF, 32'h0, 2'b00};
      tbl[11] = '{1, 64'h208, 32'h1, 4'hF, 32'h0, 2'b00};
      tbl[12] = '{1, 64'h20C, 32'h1, 4'hF, 32'h0, 2'b00};
      tbl[13] = '{0, 64'h208, 32'h0, 4'h0, 32'h1, 2'b00};
      tbl[14] = '{1, 64'h004, 32'hFF, 4'b1110, 32'h0, 2'b00};
      tbl[15] = '{0, 64'h004, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[16] = '{1, 64'h000, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00};
      tbl[17] = '{0, 64'h000, 32'h0, 4'h0, 32'h3, 2'b00};
      tbl[18] = '{0, 64'h07C, 32'h0, 4'h0, 32'h0, 2'b00};
      tbl[19] = '{0, 64'h30C, 32'h0, 4'h0, 32'h0, 2'b00};

      idle_req();
      m_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("reset bvalid", rsp.b_valid, 0);
      check("reset rvalid", rsp.r_valid, 0);
      check("reset arready", rsp.ar_ready, 1);
      check("reset awready", rsp.aw_ready, 0);
      check("reset rdata", rsp.r_data, 0);
      check("reset doorbell_irq", db_irq, 0);
      check("reset completion_irq", cmp_irq, 0);

      foreach (tbl[i]) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
            check($sformatf("vec%0d bresp", i), r, tbl[i].exp_resp);
         end else begin
            axi_read(tbl[i].addr, d, r);
            check($sformatf("vec%0d rdata", i), d, tbl[i].exp_data);
            check($sformatf("vec%0d rresp", i), r, tbl[i].exp_resp);
         end
      end

      // Doorbell first, enable afterwards: the enable write must raise the pulse.
      axi_write(64'h108, 32'h1, 4'hF, r);
      check("ch1 db without enable", db_irq, 0);
      axi_write(64'h104, 32'h1, 4'hF, r);

      // bready held low: bvalid stays up and a second write is refused.
      req.aw_addr = 64'h118; req.w_data = 32'h5A5A; req.w_strb = 4'hF;
      req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
      m_write(64'h118, 32'h5A5A, 4'hF, r);
      #1;
      check("aw accepted when idle", rsp.aw_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bvalid held", rsp.b_valid, 1);
         req.aw_addr = 64'h11C;
         req.aw_valid = (i >= 2); req.w_valid = (i >= 2);
         #1;
         check("second aw blocked", rsp.aw_ready, 0);
         check("second w blocked", rsp.w_ready, 0);
         @(negedge clk);
      end
      req.aw_valid = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bvalid released", rsp.b_valid, 0);
      axi_read(64'h118, d, r);
      check("bready-low write data", d, 32'h5A5A);
      axi_read(64'h11C, d, r);
      check("blocked write had no effect", d, 32'h0);

      // Same-cycle read and write of one register.
      axi_write(64'h010, 32'h11, 4'hF, r);
      m_write(64'h010, 32'h22, 4'hF, r);
      req.aw_addr = 64'h010; req.w_data = 32'h22; req.w_strb = 4'hF;
      req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_addr = 64'h010; req.ar_valid = 1'b1;
      #1;
      check("collide awready", rsp.aw_ready, 1);
      check("collide arready", rsp.ar_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
      check("collide rvalid", rsp.r_valid, 1);
      check("collide bvalid", rsp.b_valid, 1);
      check("collide read old value", rsp.r_data, 32'h11);
      @(negedge clk);
      axi_read(64'h010, d, r);
      check("read after collide", d, 32'h22);

      // Randomized traffic against the model.
      for (int i = 0; i < 200; i++) begin
         ch = $urandom_range(0, 4);
         wd = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 33);
         a = 64'(ch * 256 + wd * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} << 14);
         if ($urandom_range(0, 1) == 1) axi_write(a, $urandom, 4'($urandom), r);
         else axi_read(a, d, r);
      end

      // Reset during BRESP drops the pending response at once.
      req.aw_addr = 64'h000; req.w_data = 32'h0; req.w_strb = 4'hF;
      req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
      check("bvalid before reset", rsp.b_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("bvalid dropped by reset", rsp.b_valid, 0);
      check("arready in reset", rsp.ar_ready, 1);
      check("doorbell_irq in reset", db_irq, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_req();
      m_reset();
      @(negedge clk);
      axi_read(64'h000, d, r);
      check("status after reset", d, 32'h1);
      axi_read(64'h114, d, r);
      check("payload after reset", d, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
